sdram_write_arbiter: RTL and testbench
======================================

Name: sdram_write_arbiter

Overview:
- Shares the single SDRAM write port between two requesters, each using the codebase write handshake (1-cycle wr_request pulse, 1-cycle wr_done pulse).
  - Port A is terminal_stream: character cells, clears, scrolling.
  - Port B is the charset/pattern loader.
- Captures each request, grants fairly (round-robin), forwards it to the SDRAM controller, and routes wr_done back to the owner only.
- A watchdog and sticky error flags guard against a stalled controller.

Parameters:
- TIMEOUT, 1024, cycles in WAIT without sdram_wr_done before forced completion.
- TIMEOUT_WIDTH, 11, width of the watchdog counter; must hold TIMEOUT.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- a_wr_address  in  23  port A word address
- a_wr_request  in  1  port A request pulse
- a_wr_data  in  32  port A data
- a_wr_mask  in  4  port A byte mask
- a_wr_burst_length  in  9  port A burst length
- a_wr_done  out  1  port A completion pulse
- b_wr_address, b_wr_request, b_wr_data, b_wr_mask, b_wr_burst_length  in  23/1/32/4/9  port B, same meaning as port A
- b_wr_done  out  1  port B completion pulse
- sdram_wr_address  out  23  to SDRAM controller
- sdram_wr_request  out  1  to SDRAM controller
- sdram_wr_data  out  32  to SDRAM controller
- sdram_wr_mask  out  4  to SDRAM controller
- sdram_wr_burst_length  out  9  to SDRAM controller
- sdram_wr_done  in  1  controller completion pulse
- busy  out  1  high while any request is pending or in flight
- grant_b  out  1  owner of the current/last grant (0=A, 1=B)
- timeout_flag  out  1  sticky: watchdog fired
- protocol_error  out  1  sticky: request arrived while that port was already pending

Behaviour:
- Reset (reset_n low at a clk edge) takes priority over everything, including an in-flight write. Reset values:
  - state=IDLE
  - sdram_wr_request=0; sdram_wr_address=0; sdram_wr_data=0
  - sdram_wr_mask=4'b1111; sdram_wr_burst_length=1
  - a_wr_done=b_wr_done=0
  - both pending flags=0; grant_b=1, so A wins the first tie
  - watchdog=0; timeout_flag=0; protocol_error=0; busy=0
- Capture:
  - At the edge where x_wr_request=1 and x is not pending: latch address/data/mask/burst into port x's holding register and set pending_x.
  - Requester may change its inputs afterwards.
  - Request while pending_x=1: ignored, protocol_error<=1.
- State machine:
  - IDLE, no pending: stay IDLE.
  - IDLE, pending present, grant rule:
    - only one port pending: grant it;
    - both pending: grant the port other than grant_b;
    - on grant: load sdram_* from that holding register, sdram_wr_request<=1, grant_b<=chosen port, watchdog<=0, go to WAIT.
  - WAIT: sdram_wr_request<=0 (exactly 1-cycle pulse); sdram_* data fields hold until the next grant; watchdog increments each cycle.
  - WAIT, sdram_wr_done=1: owner's x_wr_done<=1 for one cycle, clear pending_owner, go to IDLE.
  - WAIT, watchdog==TIMEOUT-1 without done: same completion as on done, plus timeout_flag<=1.
  - A sdram_wr_done arriving in IDLE is ignored.
- Latency:
  - request edge E0 → pending;
  - E1 → sdram_wr_request high for the cycle after E1;
  - done sampled at Ed → x_wr_done high for the cycle after Ed;
  - next grant at Ed+1 at earliest. The minimum service interval is therefore 3 cycles per write.
- Simultaneous events:
  - New request on port x in the same cycle its done is being issued: accepted, with no protocol_error, because pending_x clears and sets in the same edge; capture wins.
  - A and B requesting at the same edge: both captured; round-robin ordering applies.
- busy = pending_a | pending_b | (state==WAIT), registered.
- Widths: the arbiter performs no arithmetic on addresses; bursts pass through unchanged. The watchdog saturates at TIMEOUT-1.

Decomposition:
- State encodings (IDLE, WAIT) and PORT_A/PORT_B constants go in a shared include alongside constant.v; TRUE/FALSE come from constant.v.
- One sub-module, write_request_latch, instantiated per port: holding register plus pending flag, with capture/clear/error outputs.

Test Plan:
- Single A request (addr 0x000010, data 0x12345678, mask F, burst 1), controller done 4 cycles after request → exactly one sdram_wr_request pulse with the same fields; a_wr_done pulses once; b_wr_done never pulses.
- A and B request on the same edge from reset → A served first, then B; grant_b reads 0 then 1; two done pulses, in order, on the correct ports.
- A issues 3 back-to-back writes while B holds one pending → service order A, B, A, A; no port starved.
- B clear burst (burst 32, address 0) → sdram_wr_burst_length=32 forwarded; busy stays high until b_wr_done.
- Controller never answers, TIMEOUT=16 → owner done pulses 16 cycles after grant; timeout_flag=1 and stays 1; next request is still served.
- A requests twice with no done between → protocol_error=1, only one write issued. reset_n=0 mid-WAIT → all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/sdram_write_arbiter_pkg.sv
// Shared types and constants for the two-port SDRAM write arbiter.
package sdram_write_arbiter_pkg;

  localparam int unsigned ADDR_W  = 23;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned MASK_W  = 4;
  localparam int unsigned BURST_W = 9;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  typedef struct packed {
    logic [ADDR_W-1:0]  address;
    logic [DATA_W-1:0]  data;
    logic [MASK_W-1:0]  mask;
    logic [BURST_W-1:0] burst_length;
  } wr_req_t;

  localparam wr_req_t WR_REQ_RESET = '{
    address:      ADDR_W'(0),
    data:         DATA_W'(0),
    mask:         {MASK_W{1'b1}},
    burst_length: BURST_W'(1)
  };

  // Round-robin choice: a lone requester wins, a tie goes to the port not granted last.
  function automatic logic pick_port(input logic pend_a, input logic pend_b, input logic last_b);
    if (pend_a && pend_b) begin
      return ~last_b;
    end
    return pend_b ? PORT_B : PORT_A;
  endfunction

endpackage

// File: rtl/sdram_write_arbiter_latch.sv
// Per-port holding register and pending flag; a capture in the clearing cycle wins.
module write_request_latch
  import sdram_write_arbiter_pkg::*;
(
  input  logic    clk,
  input  logic    reset_n,
  input  logic    request,
  input  wr_req_t req_in,
  input  logic    clear,
  output wr_req_t held,
  output logic    pending,
  output logic    pending_nxt_c,
  output logic    error_c
);

  logic capture_c;

  always_comb begin
    capture_c     = request & (~pending | clear);
    error_c       = request & pending & ~clear;
    pending_nxt_c = capture_c | (pending & ~clear);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pending <= FALSE;
      held    <= WR_REQ_RESET;
    end else begin
      pending <= pending_nxt_c;
      if (capture_c) begin
        held <= req_in;
      end
    end
  end

endmodule

// File: rtl/sdram_write_arbiter.sv
// Round-robin arbiter sharing the SDRAM write port between two requesters,
// with a completion watchdog and sticky error flags.
module sdram_write_arbiter
  import sdram_write_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT       = 1024,
  parameter int unsigned TIMEOUT_WIDTH = 11
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [ADDR_W-1:0]  a_wr_address,
  input  logic               a_wr_request,
  input  logic [DATA_W-1:0]  a_wr_data,
  input  logic [MASK_W-1:0]  a_wr_mask,
  input  logic [BURST_W-1:0] a_wr_burst_length,
  output logic               a_wr_done,
  input  logic [ADDR_W-1:0]  b_wr_address,
  input  logic               b_wr_request,
  input  logic [DATA_W-1:0]  b_wr_data,
  input  logic [MASK_W-1:0]  b_wr_mask,
  input  logic [BURST_W-1:0] b_wr_burst_length,
  output logic               b_wr_done,
  output logic [ADDR_W-1:0]  sdram_wr_address,
  output logic               sdram_wr_request,
  output logic [DATA_W-1:0]  sdram_wr_data,
  output logic [MASK_W-1:0]  sdram_wr_mask,
  output logic [BURST_W-1:0] sdram_wr_burst_length,
  input  logic               sdram_wr_done,
  output logic               busy,
  output logic               grant_b,
  output logic               timeout_flag,
  output logic               protocol_error
);

  localparam logic [TIMEOUT_WIDTH-1:0] WD_LAST = TIMEOUT_WIDTH'(TIMEOUT - 1);

  logic [0:0]               state, state_nxt;
  logic [TIMEOUT_WIDTH-1:0] watchdog, watchdog_nxt;
  wr_req_t                  fwd, fwd_nxt;
  wr_req_t                  held_a, held_b;
  logic                     pend_a, pend_b, pend_a_nxt_c, pend_b_nxt_c;
  logic                     err_a_c, err_b_c;
  logic                     clear_a_c, clear_b_c;
  logic                     req_nxt, a_done_nxt, b_done_nxt, grant_nxt;
  logic                     timeout_nxt, perr_nxt, busy_nxt, chosen;

  write_request_latch u_latch_a (
    .clk           (clk),
    .reset_n       (reset_n),
    .request       (a_wr_request),
    .req_in        ('{address: a_wr_address, data: a_wr_data,
                      mask: a_wr_mask, burst_length: a_wr_burst_length}),
    .clear         (clear_a_c),
    .held          (held_a),
    .pending       (pend_a),
    .pending_nxt_c (pend_a_nxt_c),
    .error_c       (err_a_c)
  );

  write_request_latch u_latch_b (
    .clk           (clk),
    .reset_n       (reset_n),
    .request       (b_wr_request),
    .req_in        ('{address: b_wr_address, data: b_wr_data,
                      mask: b_wr_mask, burst_length: b_wr_burst_length}),
    .clear         (clear_b_c),
    .held          (held_b),
    .pending       (pend_b),
    .pending_nxt_c (pend_b_nxt_c),
    .error_c       (err_b_c)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_nxt    = state;
    watchdog_nxt = watchdog;
    fwd_nxt      = fwd;
    req_nxt      = FALSE;
    a_done_nxt   = FALSE;
    b_done_nxt   = FALSE;
    grant_nxt    = grant_b;
    timeout_nxt  = timeout_flag;
    clear_a_c    = FALSE;
    clear_b_c    = FALSE;
    chosen       = PORT_A;

    case (state)
      ST_IDLE: begin
        if (pend_a || pend_b) begin
          chosen       = pick_port(pend_a, pend_b, grant_b);
          fwd_nxt      = (chosen == PORT_B) ? held_b : held_a;
          req_nxt      = TRUE;
          grant_nxt    = chosen;
          watchdog_nxt = TIMEOUT_WIDTH'(0);
          state_nxt    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (sdram_wr_done || (watchdog == WD_LAST)) begin
          if (grant_b == PORT_B) begin
            b_done_nxt = TRUE;
            clear_b_c  = TRUE;
          end else begin
            a_done_nxt = TRUE;
            clear_a_c  = TRUE;
          end
          if (!sdram_wr_done) begin
            timeout_nxt = TRUE;
          end
          state_nxt = ST_IDLE;
        end else begin
          watchdog_nxt = TIMEOUT_WIDTH'(watchdog + 1'b1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    perr_nxt = protocol_error | err_a_c | err_b_c;
    busy_nxt = pend_a_nxt_c | pend_b_nxt_c | (state_nxt == ST_WAIT);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state            <= ST_IDLE;
      watchdog         <= TIMEOUT_WIDTH'(0);
      fwd              <= WR_REQ_RESET;
      sdram_wr_request <= FALSE;
      a_wr_done        <= FALSE;
      b_wr_done        <= FALSE;
      grant_b          <= PORT_B;
      timeout_flag     <= FALSE;
      protocol_error   <= FALSE;
      busy             <= FALSE;
    end else begin
      state            <= state_nxt;
      watchdog         <= watchdog_nxt;
      fwd              <= fwd_nxt;
      sdram_wr_request <= req_nxt;
      a_wr_done        <= a_done_nxt;
      b_wr_done        <= b_done_nxt;
      grant_b          <= grant_nxt;
      timeout_flag     <= timeout_nxt;
      protocol_error   <= perr_nxt;
      busy             <= busy_nxt;
    end
  end

  assign sdram_wr_address      = fwd.address;
  assign sdram_wr_data         = fwd.data;
  assign sdram_wr_mask         = fwd.mask;
  assign sdram_wr_burst_length = fwd.burst_length;

endmodule

// File: tb/tb_sdram_write_arbiter.sv
// Directed and random bench for sdram_write_arbiter against a transaction-level model.
module tb_sdram_write_arbiter;
  import sdram_write_arbiter_pkg::*;

  localparam int TO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset_n = 1'b0;
  logic [ADDR_W-1:0]  a_wr_address = '0, b_wr_address = '0, sdram_wr_address;
  logic               a_wr_request = 1'b0, b_wr_request = 1'b0, sdram_wr_request;
  logic [DATA_W-1:0]  a_wr_data = '0, b_wr_data = '0, sdram_wr_data;
  logic [MASK_W-1:0]  a_wr_mask = '0, b_wr_mask = '0, sdram_wr_mask;
  logic [BURST_W-1:0] a_wr_burst_length = '0, b_wr_burst_length = '0, sdram_wr_burst_length;
  logic               a_wr_done, b_wr_done, sdram_wr_done = 1'b0;
  logic               busy, grant_b, timeout_flag, protocol_error;

  sdram_write_arbiter #(.TIMEOUT(TO), .TIMEOUT_WIDTH(11)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_wr_address(a_wr_address), .a_wr_request(a_wr_request), .a_wr_data(a_wr_data),
    .a_wr_mask(a_wr_mask), .a_wr_burst_length(a_wr_burst_length), .a_wr_done(a_wr_done),
    .b_wr_address(b_wr_address), .b_wr_request(b_wr_request), .b_wr_data(b_wr_data),
    .b_wr_mask(b_wr_mask), .b_wr_burst_length(b_wr_burst_length), .b_wr_done(b_wr_done),
    .sdram_wr_address(sdram_wr_address), .sdram_wr_request(sdram_wr_request),
    .sdram_wr_data(sdram_wr_data), .sdram_wr_mask(sdram_wr_mask),
    .sdram_wr_burst_length(sdram_wr_burst_length), .sdram_wr_done(sdram_wr_done),
    .busy(busy), .grant_b(grant_b), .timeout_flag(timeout_flag), .protocol_error(protocol_error)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: two request slots, one write in flight, last-served port.
  wr_req_t slot [2];
  bit      full [2];
  bit      inflight, owner, last_srv;
  int      age;
  wr_req_t m_fwd;
  bit      e_req, e_adone, e_bdone, e_to, e_pe;

  // Controller emulation and observation bookkeeping.
  int  cd = -1, rmode = 4, cyc_n = 0, g_cyc = 0, a_lat = 0;
  int  n_req = 0, n_adone = 0, n_bdone = 0;
  bit  spur = 1'b0;
  logic [BURST_W-1:0] last_burst;
  int  owners[$];
  wr_req_t idle_req;

  function automatic wr_req_t rnd_req();
    wr_req_t r;
    r.address      = ADDR_W'($urandom);
    r.data         = DATA_W'($urandom);
    r.mask         = MASK_W'($urandom);
    r.burst_length = BURST_W'($urandom);
    return r;
  endfunction

  function automatic wr_req_t mk(input int addr, input int data, input int mask, input int bl);
    wr_req_t r;
    r.address      = ADDR_W'(addr);
    r.data         = DATA_W'(data);
    r.mask         = MASK_W'(mask);
    r.burst_length = BURST_W'(bl);
    return r;
  endfunction

  function automatic void model_step(input bit ra, input wr_req_t pa, input bit rb,
                                     input wr_req_t pb, input bit dn, input bit rst_n);
    e_req = 0; e_adone = 0; e_bdone = 0;
    if (!rst_n) begin
      full[0] = 0; full[1] = 0; inflight = 0; last_srv = 1; age = 0;
      m_fwd = mk(0, 0, 15, 1); e_to = 0; e_pe = 0;
      return;
    end
    if (inflight) begin
      age++;
      if (dn || age == TO) begin
        if (owner) e_bdone = 1; else e_adone = 1;
        full[owner] = 0;
        inflight = 0;
        if (!dn) e_to = 1;
      end
    end else if (full[0] || full[1]) begin
      owner    = (full[0] && full[1]) ? !last_srv : full[1];
      last_srv = owner;
      m_fwd    = slot[owner];
      e_req    = 1;
      inflight = 1;
      age      = 0;
    end
    if (ra) begin
      if (full[0]) e_pe = 1; else begin slot[0] = pa; full[0] = 1; end
    end
    if (rb) begin
      if (full[1]) e_pe = 1; else begin slot[1] = pb; full[1] = 1; end
    end
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h at cycle %0d", tag, got, exp, cyc_n);
    end
  endtask

  task automatic cyc(input bit ra, input wr_req_t pa, input bit rb, input wr_req_t pb);
    bit dn;
    dn = (cd == 1);
    if (cd > 0) cd--;
    if (spur && $urandom_range(0, 19) == 0) dn = 1;
    a_wr_request = ra; a_wr_address = pa.address; a_wr_data = pa.data;
    a_wr_mask = pa.mask; a_wr_burst_length = pa.burst_length;
    b_wr_request = rb; b_wr_address = pb.address; b_wr_data = pb.data;
    b_wr_mask = pb.mask; b_wr_burst_length = pb.burst_length;
    sdram_wr_done = dn;
    @(posedge clk);
    model_step(ra, pa, rb, pb, dn, reset_n);
    #1;
    cyc_n++;
    chk("sdram_wr_request", 64'(sdram_wr_request), 64'(e_req));
    chk("sdram_wr_address", 64'(sdram_wr_address), 64'(m_fwd.address));
    chk("sdram_wr_data", 64'(sdram_wr_data), 64'(m_fwd.data));
    chk("sdram_wr_mask", 64'(sdram_wr_mask), 64'(m_fwd.mask));
    chk("sdram_wr_burst_length", 64'(sdram_wr_burst_length), 64'(m_fwd.burst_length));
    chk("a_wr_done", 64'(a_wr_done), 64'(e_adone));
    chk("b_wr_done", 64'(b_wr_done), 64'(e_bdone));
    chk("busy", 64'(busy), 64'(full[0] | full[1] | inflight));
    chk("grant_b", 64'(grant_b), 64'(last_srv));
    chk("timeout_flag", 64'(timeout_flag), 64'(e_to));
    chk("protocol_error", 64'(protocol_error), 64'(e_pe));
    if (sdram_wr_request === 1'b1) begin
      owners.push_back(int'(grant_b));
      n_req++;
      g_cyc = cyc_n;
      last_burst = sdram_wr_burst_length;
      if (rmode < 0) cd = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 6));
      else cd = rmode;
    end
    if (a_wr_done === 1'b1) begin n_adone++; a_lat = cyc_n - g_cyc; end
    if (b_wr_done === 1'b1) n_bdone++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, idle_req, 0, idle_req);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    cd = -1;
    idle(2);
    reset_n = 1'b1;
    owners.delete();
    n_req = 0; n_adone = 0; n_bdone = 0;
  endtask

  function automatic logic [63:0] own(input int i);
    return (i < owners.size()) ? 64'(owners[i]) : 64'hDEAD;
  endfunction

  initial begin
    #2000000;
    $display("FAIL global_time_limit observed=expired required=finish");
    $fatal(1, "time limit");
  end

  initial begin
    bit a_prev;
    int a_left;
    idle_req = mk(0, 0, 0, 0);

    // Reset values, then a single A write with done 4 cycles after the request.
    do_reset();
    rmode = 4;
    cyc(1, mk(32'h10, 32'h12345678, 15, 1), 0, idle_req);
    idle(10);
    chk("t1_req_count", 64'(n_req), 64'd1);
    chk("t1_a_done_count", 64'(n_adone), 64'd1);
    chk("t1_b_done_count", 64'(n_bdone), 64'd0);

    // Simultaneous A and B from reset: A first, then B.
    do_reset();
    cyc(1, rnd_req(), 1, rnd_req());
    idle(20);
    chk("t2_owner0", own(0), 64'd0);
    chk("t2_owner1", own(1), 64'd1);
    chk("t2_done_counts", 64'({n_adone[15:0], n_bdone[15:0]}), 64'h0001_0001);

    // A re-requests after each done while B holds one pending.
    do_reset();
    cyc(1, rnd_req(), 1, rnd_req());
    a_prev = 0; a_left = 2;
    for (int i = 0; i < 60; i++) begin
      bit go;
      go = a_prev && (a_left > 0);
      if (go) a_left--;
      cyc(go, rnd_req(), 0, idle_req);
      a_prev = (a_wr_done === 1'b1);
    end
    chk("t3_writes", 64'(owners.size()), 64'd4);
    chk("t3_order0", own(0), 64'd0);
    chk("t3_order1", own(1), 64'd1);
    chk("t3_order2", own(2), 64'd0);
    chk("t3_order3", own(3), 64'd0);

    // B clear burst of 32 words at address 0.
    do_reset();
    rmode = 6;
    cyc(0, idle_req, 1, mk(0, 0, 15, 32));
    idle(3);
    chk("t4_burst", 64'(last_burst), 64'd32);
    chk("t4_busy_in_wait", 64'(busy), 64'd1);
    idle(8);
    chk("t4_b_done_count", 64'(n_bdone), 64'd1);

    // Controller silent: watchdog completes the write 16 cycles after grant.
    do_reset();
    rmode = 0;
    cyc(1, rnd_req(), 0, idle_req);
    idle(TO + 4);
    chk("t5_a_done_count", 64'(n_adone), 64'd1);
    chk("t5_latency", 64'(a_lat), 64'(TO));
    chk("t5_timeout_flag", 64'(timeout_flag), 64'd1);
    rmode = 3;
    cyc(1, rnd_req(), 0, idle_req);
    idle(8);
    chk("t5_served_after", 64'(n_adone), 64'd2);
    chk("t5_flag_sticky", 64'(timeout_flag), 64'd1);

    // Double request with no done between: one write, protocol_error set.
    do_reset();
    rmode = 4;
    cyc(1, rnd_req(), 0, idle_req);
    cyc(1, rnd_req(), 0, idle_req);
    idle(10);
    chk("t6_req_count", 64'(n_req), 64'd1);
    chk("t6_protocol_error", 64'(protocol_error), 64'd1);

    // Reset asserted mid-WAIT.
    do_reset();
    rmode = 0;
    cyc(1, rnd_req(), 1, rnd_req());
    idle(3);
    chk("t7_busy_before_reset", 64'(busy), 64'd1);
    do_reset();
    idle(3);

    // Random traffic with random response delays, silent controller and stray dones.
    rmode = -1;
    spur = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 99) < 25, rnd_req(), $urandom_range(0, 99) < 25, rnd_req());
      if ($urandom_range(0, 999) == 0) do_reset();
    end
    spur = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
